ifu_fetch: RTL

Instruction-fetch stage directly downstream of the PC register. Consumes the current PC, fetches the instruction word from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. Drives pc_stall back to the next-PC mux so the PC advances only when an instruction is accepted or a flush redirects it. Supports multi-cycle memories, abandons a fetch on flush, and traps misaligned or timed-out fetches.

---
 rtl/ifu_fetch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction-fetch stage that sits directly after the PC register. It takes
// the current PC, reads the matching word from instruction memory over a
// req/ack handshake, and hands it to decode over a valid/ready handshake.
// o_pc_stall tells the next-PC mux whether the PC may advance. The PC advances
// only when decode accepts an instruction or when a flush redirects the PC.
//
// Each instruction walks LOAD -> FETCH -> HOLD. A misaligned PC or a memory
// that never acknowledges parks the stage in ERR until reset.
//
// Optional build macro:
//   FETCH_RANGE_CHK_EN - traps PCs outside [ADDR_BASE, ADDR_BASE + 4*IM_WORDS)
//                        in LOAD instead of letting im_addr wrap.
//
// Ports:
//   i_clk           clock, all state changes on the rising edge
//   i_reset         synchronous active-low reset
//   i_pc            current PC from the PC register
//   o_pc_stall      1 = next-PC logic must hold the current PC
//   i_flush         redirect; drops any in-flight or held instruction
//   o_im_req        instruction-memory request
//   o_im_addr       instruction-memory word address
//   i_im_ack        memory acknowledge, i_im_rdata valid in the same cycle
//   i_im_rdata      instruction word from memory
//   o_instr         fetched instruction
//   o_instr_valid   o_instr holds a valid instruction
//   i_instr_ready   decode accepts o_instr
//   o_fetch_err     sticky fetch trap
// ----------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] ADDR_BASE = 32'h00003000,
    parameter int          IM_AW     = 10,
    parameter int          IM_WORDS  = 1024,
    parameter int          TIMEOUT   = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc,
    output logic             o_pc_stall,
    input  logic             i_flush,
    output logic             o_im_req,
    output logic [IM_AW-1:0] o_im_addr,
    input  logic             i_im_ack,
    input  logic [31:0]      i_im_rdata,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    input  logic             i_instr_ready,
    output logic             o_fetch_err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } stateT;

    stateT       r_state;
    stateT       w_nextState;
    logic [31:0] r_reqPc;
    logic [31:0] r_instr;
    logic        r_instrValid;
    logic        r_fetchErr;
    logic [7:0]  r_count;

    logic [31:0] w_offset;
    logic        w_unusedOffsetBits;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_flushActive;
    logic        w_ackTaken;

    // The word address comes from the PC latched in LOAD. It therefore stays
    // stable for the whole request even if the PC input moves. Only the word
    // bits inside the memory are kept. Any higher bits wrap silently.
    assign w_offset           = r_reqPc - ADDR_BASE;
    assign o_im_addr          = w_offset[IM_AW+1:2];
    assign w_unusedOffsetBits = ^{w_offset[31:IM_AW+2], w_offset[1:0]};

    assign w_misaligned = (i_pc[1:0] != 2'b00);

`ifdef FETCH_RANGE_CHK_EN
    // The upper bound is computed one bit wider so that a base near the top of
    // the address space cannot overflow the comparison.
    localparam logic [32:0] RANGE_END = {1'b0, ADDR_BASE} + 33'(4 * IM_WORDS);

    assign w_outOfRange = (i_pc < ADDR_BASE) || ({1'b0, i_pc} >= RANGE_END);
`else
    localparam int unusedImWords = IM_WORDS;

    assign w_outOfRange = 1'b0;
`endif

    // ERR deliberately ignores flush. Only a reset can clear a trap.
    assign w_flushActive = i_flush && (r_state != ERR);

    // An acknowledge counts only while a request is actually on the bus.
    assign w_ackTaken = (r_state == FETCH) && i_im_ack && !w_flushActive;

    // Next-state and handshake outputs. Flush beats both ack and ready.
    // Reset is applied last so that it forces the request low and the stall
    // high in the reset cycle, whatever state the FSM was in.
    always_comb begin
        w_nextState = r_state;
        o_im_req    = 1'b0;
        o_pc_stall  = 1'b1;

        case (r_state)
            LOAD: begin
                if (w_misaligned || w_outOfRange) begin
                    w_nextState = ERR;
                end else begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                o_im_req = 1'b1;
                if (i_im_ack) begin
                    w_nextState = HOLD;
                end else if (r_count == 8'(TIMEOUT - 1)) begin
                    w_nextState = ERR;
                end
            end
            HOLD: begin
                o_pc_stall = !i_instr_ready;
                if (i_instr_ready) begin
                    w_nextState = LOAD;
                end
            end
            ERR: begin
                w_nextState = ERR;
            end
            default: begin
                w_nextState = LOAD;
            end
        endcase

        if (w_flushActive) begin
            w_nextState = LOAD;
            o_im_req    = 1'b0;
            o_pc_stall  = 1'b0;
        end

        if (!i_reset) begin
            w_nextState = LOAD;
            o_im_req    = 1'b0;
            o_pc_stall  = 1'b1;
        end
    end

    // State register plus the datapath registers.
    // - The FETCH cycle counter is cleared in LOAD, so every new request gets
    //   the full TIMEOUT budget.
    // - Valid follows entry into HOLD. This clears it on handoff, on flush and
    //   on a trap.
    // - The error flag only ever sets. ERR is never left except through reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= LOAD;
            r_reqPc      <= 32'h0;
            r_instr      <= 32'h0;
            r_instrValid <= 1'b0;
            r_fetchErr   <= 1'b0;
            r_count      <= 8'h0;
        end else begin
            r_state      <= w_nextState;
            r_instrValid <= (w_nextState == HOLD);

            if (r_state == LOAD) begin
                r_reqPc <= i_pc;
                r_count <= 8'h0;
            end else if (r_state == FETCH) begin
                r_count <= r_count + 8'h1;
            end

            if (w_ackTaken) begin
                r_instr <= i_im_rdata;
            end

            if (w_nextState == ERR) begin
                r_fetchErr <= 1'b1;
            end
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_valid = r_instrValid;
    assign o_fetch_err   = r_fetchErr;

endmodule
